// File: rtl/uart_echo.sv
// 8N1 UART receiver and transmitter: each well-framed received byte is shown on
// active-low LEDs and echoed back on uart_tx at the same bit rate.
module uart_echo #(
    parameter int unsigned DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       btn,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [5:0] led
);

    typedef logic [7:0] cnt_t;

    localparam cnt_t HALF_LAST = cnt_t'(DELAY_FRAMES / 2 - 1);
    localparam cnt_t BIT_LAST  = cnt_t'(DELAY_FRAMES - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_DONE
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    logic       rx_meta_q;
    logic       rx_sync_q;

    rx_state_e  rx_state_q, rx_state_d;
    cnt_t       rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_idx_q, rx_idx_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [5:0] led_q, led_d;
    logic       pend_q, pend_d;
    logic [7:0] pend_byte_q, pend_byte_d;
    logic       rx_done;

    tx_state_e  tx_state_q, tx_state_d;
    cnt_t       tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_idx_q, tx_idx_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_q, tx_d;
    logic       tx_load;
    logic       tx_bit_end;

    assign uart_tx    = tx_q;
    assign led        = led_q;
    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    // ---------------- receive side ----------------
    always_ff @(posedge clk) begin
        if (!btn) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_idx_q    <= '0;
            rx_shift_q  <= '0;
            led_q       <= '1;
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
        end else begin
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            led_q       <= led_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (!rx_sync_q) rx_state_d = RX_START;
            RX_START: if (rx_cnt_q == HALF_LAST) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt_q == BIT_LAST && rx_idx_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_cnt_q == BIT_LAST) rx_state_d = rx_sync_q ? RX_DONE : RX_IDLE;
            RX_DONE:  rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_cnt_d   = rx_cnt_q + 8'd1;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        led_d      = led_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: rx_cnt_d = '0;
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = rx_idx_q + 3'd1;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                end
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) rx_cnt_d = '0;
            RX_DONE: begin
                rx_cnt_d = '0;
                led_d    = ~rx_shift_q[5:0];
                rx_done  = 1'b1;
            end
            default: rx_cnt_d = '0;
        endcase
    end

    // A newly received byte wins the single pending slot; the transmitter takes
    // the old slot contents if it loads on that same cycle.
    always_comb begin
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        if (tx_load) pend_d = 1'b0;
        if (rx_done) begin
            pend_d      = 1'b1;
            pend_byte_d = rx_shift_q;
        end
    end

    // ---------------- transmit side ----------------
    always_ff @(posedge clk) begin
        if (!btn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:  if (pend_q) tx_state_d = TX_START;
            TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_idx_q == 3'd7) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_state_d = pend_q ? TX_START : TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // The line level is registered from the next state so uart_tx never glitches.
    always_comb begin
        tx_cnt_d   = tx_cnt_q + 8'd1;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (pend_q) begin
                    tx_shift_d = pend_byte_q;
                    tx_load    = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    tx_idx_d = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    tx_idx_d = tx_idx_q + 3'd1;
                    if (tx_idx_q != 3'd7) tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (pend_q) begin
                        tx_shift_d = pend_byte_q;
                        tx_load    = 1'b1;
                    end
                end
            end
            default: tx_cnt_d = '0;
        endcase

        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_echo.sv
// Randomised self-checking bench for uart_echo: serial frames in, LED state and
// decoded echo frames checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_uart_echo;

    localparam int unsigned DF = 8;

    logic       clk     = 1'b0;
    logic       btn     = 1'b0;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [5:0] led;

    always #1 clk = ~clk;

    uart_echo #(.DELAY_FRAMES(DF)) dut (
        .clk    (clk),
        .btn    (btn),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .led    (led)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned cyc      = 0;

    logic [7:0]  got_q[$];
    int unsigned got_t[$];
    logic [7:0]  exp_q[$];
    logic [5:0]  exp_led;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Reference serial receiver on uart_tx: sample each bit at its centre.
    initial begin
        logic [7:0]  b;
        int unsigned t0;
        forever begin
            @(negedge clk);
            if (btn && uart_tx === 1'b0) begin
                t0 = cyc;
                repeat (DF / 2) @(negedge clk);
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (DF) @(negedge clk);
                        b[i] = uart_tx;
                    end
                    repeat (DF) @(negedge clk);
                    check("tx_stop", {31'd0, uart_tx}, 32'd1);
                    got_q.push_back(b);
                    got_t.push_back(t0);
                end
            end
        end
    end

    // Drives one frame; checks the LED result of the previous frame once this
    // frame's start bit is over (1.5 bit-times after the previous stop midpoint).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        wait_cycles(DF);
        check("led", {26'd0, led}, {26'd0, exp_led});
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cycles(DF);
        end
        uart_rx = stop_bit;
        wait_cycles(DF);
        uart_rx = 1'b1;
        if (stop_bit) begin
            exp_led = ~b[5:0];
            exp_q.push_back(b);
        end
    endtask

    task automatic drain_echo(input string tag);
        int unsigned lim;
        lim = 0;
        while (got_q.size() < exp_q.size() && lim < 2000) begin
            wait_cycles(1);
            lim++;
        end
        wait_cycles(100);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(tag, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic watch_tx_idle(input int unsigned n, output logic seen_low);
        seen_low = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) seen_low = 1'b1;
        end
    endtask

    initial begin
        logic       seen_low;
        logic [7:0] b;
        logic       bad;
        logic [7:0] part;

        exp_led = '1;
        btn     = 1'b0;
        uart_rx = 1'b1;
        wait_cycles(4);
        check("rst_led_hold", {26'd0, led}, 32'h3F);
        check("rst_tx_hold", {31'd0, uart_tx}, 32'd1);
        btn = 1'b1;
        watch_tx_idle(200, seen_low);
        check("idle_tx", {31'd0, seen_low}, 32'd0);
        check("idle_led", {26'd0, led}, 32'h3F);

        // single byte 0x61
        send_frame(8'h61, 1'b1);
        wait_cycles(2 * DF);
        check("led_61", {26'd0, led}, {26'd0, 6'b011110});
        drain_echo("echo_61");

        // short low pulse must be rejected
        uart_rx = 1'b0;
        wait_cycles(2);
        uart_rx = 1'b1;
        watch_tx_idle(100, seen_low);
        check("glitch_tx", {31'd0, seen_low}, 32'd0);
        check("glitch_led", {26'd0, led}, {26'd0, exp_led});

        // framing error: stop bit low
        send_frame(8'h3C, 1'b0);
        wait_cycles(3 * DF);
        check("frm_led", {26'd0, led}, {26'd0, exp_led});
        drain_echo("frm_echo");

        // back-to-back frames with no idle gap
        got_t.delete();
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        wait_cycles(2 * DF);
        check("led_aa", {26'd0, led}, {26'd0, 6'b010101});
        drain_echo("b2b");
        if (got_t.size() >= 2) check("b2b_gap", got_t[1] - got_t[0], 10 * DF);
        else check("b2b_frames", got_t.size(), 2);

        // reset during data bit 4
        part    = 8'h96;
        uart_rx = 1'b0;
        wait_cycles(DF);
        for (int i = 0; i < 4; i++) begin
            uart_rx = part[i];
            wait_cycles(DF);
        end
        uart_rx = part[4];
        wait_cycles(DF / 2);
        btn = 1'b0;
        wait_cycles(4);
        uart_rx = 1'b1;
        btn     = 1'b1;
        wait_cycles(2);
        check("midrst_led", {26'd0, led}, 32'h3F);
        check("midrst_tx", {31'd0, uart_tx}, 32'd1);
        exp_led = '1;
        exp_q.delete();
        wait_cycles(3 * DF);
        send_frame(8'h0F, 1'b1);
        wait_cycles(2 * DF);
        check("led_0f", {26'd0, led}, {26'd0, 6'b110000});
        drain_echo("echo_0f");

        // random traffic with occasional framing errors and random gaps
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_frame(b, !bad);
            wait_cycles(DF * ($urandom_range(0, 2) + (bad ? 1 : 0)));
        end
        wait_cycles(2 * DF);
        check("rand_led", {26'd0, led}, {26'd0, exp_led});
        drain_echo("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/uart_echo.md
Name: uart_echo

Overview:
- 8N1 UART receiver/transmitter for the FPGA top level.
- Received bytes are shown on six active-low LEDs: LED pin driven low means LED on.
- Each correctly framed byte is echoed back on uart_tx at the same bit rate.
- One clock domain; bit timing comes from a clock-cycles-per-bit parameter.

Parameters:
- DELAY_FRAMES, default 234, clock cycles per UART bit (27 MHz / 115200). Legal range 4..255, 8-bit value. Bench uses 8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- btn  input  1  synchronous active-low reset (0 = reset).
- uart_rx  input  1  serial receive line, idle high, asynchronous to clk.
- uart_tx  output  1  serial transmit line, idle high.
- led  output  6  active-low LED drive; shows inverted low 6 bits of last good received byte.

Behaviour:
- Reset (btn=0 at a clk edge):
  - both FSMs go to IDLE; counters clear.
  - uart_tx=1, led=6'b111111 (all off), pending-TX flag cleared.
  - Reset mid-frame abandons the frame with no LED update and no echo.
- RX input: uart_rx passes through a 2-flop synchronizer before use. All timing below is relative to the synchronized signal (2-cycle offset from the pin).
- RX FSM states and transitions:
  - IDLE: on synchronized rx=0, go to START; clear counter.
  - START: count DELAY_FRAMES/2 cycles (integer divide). At the end, if rx=0, go to DATA with bit index 0 and counter cleared. If rx=1, treat as a glitch and return to IDLE.
  - DATA: every DELAY_FRAMES cycles, sample rx into bit[index], LSB first. After bit 7, go to STOP.
  - STOP: after DELAY_FRAMES cycles, sample rx.
    - If 1: on the next edge, latch byte, set led = ~byte[5:0], raise pending-TX flag with that byte. Go to IDLE.
    - If 0 (framing error): discard byte, leave led unchanged, go to IDLE.
  - Sampling lands mid-bit. Max clock mismatch tolerated is about ±4%.
- TX FSM states and transitions:
  - IDLE: uart_tx=1. If pending flag is set, load the byte, clear the flag, go to START.
  - START: uart_tx=0 for DELAY_FRAMES cycles.
  - DATA: 8 bits LSB first, each held DELAY_FRAMES cycles.
  - STOP: uart_tx=1 for DELAY_FRAMES cycles, then IDLE.
  - Back-to-back frames: the next frame may start on the cycle after STOP ends.
- Simultaneous events:
  - A new byte arriving while TX is busy overwrites the single pending slot. Only the newest byte is echoed after the current frame; older pending bytes are dropped.
  - RX and TX operate independently; full duplex.
- uart_tx is driven from a register (glitch-free).

Test Plan:
- Reset: btn=0 for 4 cycles, then 1 -> led=111111, uart_tx=1, no activity for 200 cycles with rx idle.
- Receive 0x61, DELAY_FRAMES=8, 16 ns bits at 2 ns clk:
  - start bit, then bits 1,0,0,0,0,1,1,0, then stop 1 -> led=011110 within 2 bit-times after stop midpoint.
  - uart_tx then emits start, 1,0,0,0,0,1,1,0, stop, each bit 8 cycles.
- Glitch: rx low for 2 cycles only -> no LED change, uart_tx stays 1, RX back to IDLE.
- Framing error: send 0x3C with stop bit 0 -> led unchanged from prior value; no echo.
- Back-to-back: 0x55 then 0xAA with no idle gap -> led=101010 then 010101. Both echoed in order, frames contiguous.
- Reset mid-frame: btn=0 during data bit 4 of a byte -> led=111111, uart_tx=1. The next full byte 0x0F is received correctly, giving led=110000.
